// File: rtl/universal_shift_register.sv
// Universal shift register: a command is accepted in IDLE. It either loads,
// holds or clears the register in one edge, or runs a multi-cycle
// shift/rotate sequence with one step per clock edge.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   start/mode/amt/D - command strobe, op code, step count, load data (IDLE only)
//   sin_l / sin_r    - serial inputs for right / left shifts (sampled every step)
//   Q                - register contents
//   sout_l / sout_r  - Q[N-1] / Q[0]
//   busy / done      - RUN indicator / one-cycle completion pulse
module universal_shift_register #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic [W-1:0] amt,
  input  logic [N-1:0] D,
  input  logic         sin_l,
  input  logic         sin_r,
  output logic [N-1:0] Q,
  output logic         sout_l,
  output logic         sout_r,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_SAR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  state_e       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [2:0]   mode_q, mode_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // One single-bit step of a shift/rotate op code.
  function automatic logic [N-1:0] step(input logic [2:0]   m,
                                        input logic [N-1:0] v,
                                        input logic         sl,
                                        input logic         sr);
    logic [N-1:0] r;
    r = v;
    case (m)
      M_SHL:   r = {v[N-2:0], sr};
      M_SHR:   r = {sl, v[N-1:1]};
      M_SAR:   r = {v[N-1], v[N-1:1]};
      M_ROL:   r = {v[N-2:0], v[N-1]};
      M_ROR:   r = {v[0], v[N-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mode)
            M_HOLD: begin
              q_d     = q_q;
              state_d = S_DONE;
            end
            M_LOAD: begin
              q_d     = D;
              state_d = S_DONE;
            end
            M_CLR: begin
              q_d     = '0;
              state_d = S_DONE;
            end
            default: begin
              mode_d  = mode;
              cnt_d   = amt;
              state_d = (amt == '0) ? S_DONE : S_RUN;
            end
          endcase
        end
      end
      S_RUN: begin
        q_d   = step(mode_q, q_q, sin_l, sin_r);
        cnt_d = cnt_q - W'(1);
        if (cnt_q == W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q      = q_q;
  assign sout_l = q_q[N-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (N=8, W=4): directed
// scenarios plus random commands, checked against a command-level model.
module tb_universal_shift_register;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] D;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] Q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mq;

  universal_shift_register #(.N(8), .W(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .mode   (mode),
    .amt    (amt),
    .D      (D),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .Q      (Q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One step of a shift/rotate expressed as plain integer arithmetic.
  function automatic logic [7:0] model_step(input logic [2:0] m, input logic [7:0] v,
                                            input logic sl, input logic sr);
    int x;
    x = int'(v);
    case (m)
      3'd2:    x = (x * 2 + int'(sr)) % 256;
      3'd3:    x = x / 2 + int'(sl) * 128;
      3'd4:    x = x / 2 + ((x >= 128) ? 128 : 0);
      3'd5:    x = (x * 2) % 256 + x / 128;
      3'd6:    x = x / 2 + (x % 2) * 128;
      default: x = x;
    endcase
    return 8'(x);
  endfunction

  // Drive don't-care command inputs and fresh serial bits for the next edge.
  task automatic drive_junk(input bit guard, input bit use_pat, input logic [15:0] pat, input int idx);
    start = guard ? 1'b1 : 1'($urandom);
    mode  = guard ? 3'b111 : 3'($urandom);
    amt   = 4'($urandom);
    D     = 8'($urandom);
    sin_r = 1'($urandom);
    sin_l = use_pat ? pat[4'(idx)] : 1'($urandom);
  endtask

  // Issue one command at the next edge and follow it through DONE back to IDLE.
  task automatic issue(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                       input bit guard, input bit use_pat, input logic [15:0] pat);
    int   steps;
    logic sl, sr;
    steps = (m == 3'd0 || m == 3'd1 || m == 3'd7) ? 0 : int'(a);
    start = 1'b1;
    mode  = m;
    amt   = a;
    D     = d;
    sin_l = 1'($urandom);
    sin_r = 1'($urandom);
    @(posedge clk); #1;
    if (m == 3'd1) mq = d;
    else if (m == 3'd7) mq = 8'h00;
    check("cmd_q", 32'(Q), 32'(mq));
    check("cmd_busy", 32'(busy), 32'(steps != 0));
    check("cmd_done", 32'(done), 32'(steps == 0));
    drive_junk(guard, use_pat, pat, 0);
    for (int i = 1; i <= steps; i++) begin
      sl = sin_l;
      sr = sin_r;
      @(posedge clk); #1;
      mq = model_step(m, mq, sl, sr);
      check("step_q", 32'(Q), 32'(mq));
      check("step_sout_l", 32'(sout_l), 32'(mq[7]));
      check("step_sout_r", 32'(sout_r), 32'(mq[0]));
      check("step_busy", 32'(busy), 32'(i < steps));
      check("step_done", 32'(done), 32'(i == steps));
      drive_junk(guard, use_pat, pat, i);
    end
    // The edge ending DONE must ignore whatever junk command is presented.
    @(posedge clk); #1;
    check("tail_q", 32'(Q), 32'(mq));
    check("tail_busy", 32'(busy), 32'd0);
    check("tail_done", 32'(done), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    mode    = 3'd0;
    amt     = 4'd0;
    D       = 8'h00;
    sin_l   = 1'b0;
    sin_r   = 1'b0;
    mq      = 8'h00;
    #2 reset_n = 1'b0;
    #5;
    check("rst_q", 32'(Q), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_hold_q", 32'(Q), 32'h00);

    // Load, arithmetic shift, rotates, serial stream.
    issue(3'd1, 4'd0, 8'hA5, 1'b0, 1'b0, 16'h0);
    check("load_a5", 32'(Q), 32'hA5);
    issue(3'd1, 4'd0, 8'h96, 1'b0, 1'b0, 16'h0);
    issue(3'd4, 4'd3, 8'h00, 1'b0, 1'b0, 16'h0);
    check("sar_f2", 32'(Q), 32'hF2);
    issue(3'd1, 4'd0, 8'h81, 1'b0, 1'b0, 16'h0);
    issue(3'd5, 4'd9, 8'h00, 1'b0, 1'b0, 16'h0);
    check("rol9_03", 32'(Q), 32'h03);
    issue(3'd1, 4'd0, 8'h3C, 1'b0, 1'b0, 16'h0);
    issue(3'd6, 4'd8, 8'h00, 1'b0, 1'b0, 16'h0);
    check("ror8_3c", 32'(Q), 32'h3C);
    issue(3'd7, 4'd0, 8'hFF, 1'b0, 1'b0, 16'h0);
    issue(3'd3, 4'd8, 8'h00, 1'b0, 1'b1, 16'h004D);
    check("stream_4d", 32'(Q), 32'h4D);

    // Clear strobed throughout a run is ignored; amt=0 shift is a no-op.
    issue(3'd1, 4'd0, 8'hC3, 1'b0, 1'b0, 16'h0);
    issue(3'd2, 4'd5, 8'h00, 1'b1, 1'b0, 16'h0);
    check("guard_nonzero", 32'(Q != 8'h00 || mq == 8'h00), 32'd1);
    issue(3'd2, 4'd0, 8'h00, 1'b0, 1'b0, 16'h0);
    issue(3'd0, 4'd0, 8'h11, 1'b0, 1'b0, 16'h0);

    // Random commands, including step counts beyond N.
    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 11)), 8'($urandom),
            1'b0, 1'b0, 16'h0);
    end

    // Asynchronous reset in the middle of a run.
    issue(3'd1, 4'd0, 8'h33, 1'b0, 1'b0, 16'h0);
    start = 1'b1;
    mode  = 3'd5;
    amt   = 4'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    check("prerst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_q", 32'(Q), 32'h00);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    start = 1'b1;
    mode  = 3'd1;
    D     = 8'h5A;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("inrst_q", 32'(Q), 32'h00);
      check("inrst_busy", 32'(busy), 32'd0);
      check("inrst_done", 32'(done), 32'd0);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    mq = 8'h5A;
    check("postrst_load_q", 32'(Q), 32'h5A);
    check("postrst_done", 32'(done), 32'd1);
    check("postrst_busy", 32'(busy), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    check("postrst_tail_done", 32'(done), 32'd0);
    check("postrst_tail_q", 32'(Q), 32'(mq));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter N, default 8: register width in bits; legal values N >= 2.
REQ-002 Parameter W, default $clog2(N+1): width of the shift-amount field.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  command strobe; sampled only in IDLE.
REQ-006 mode  input  3  operation code, sampled with start.
REQ-007 amt  input  W  step count for shift/rotate modes, sampled with start.
REQ-008 D  input  N  parallel load data, sampled with start.
REQ-009 sin_l  input  1  serial input entering the MSB on right shifts.
REQ-010 sin_r  input  1  serial input entering the LSB on left shifts.
REQ-011 Q  output  N  register contents, driven directly from the state flops.
REQ-012 sout_l  output  1  equals Q[N-1].
REQ-013 sout_r  output  1  equals Q[0].
REQ-014 busy  output  1  high while the FSM is in RUN.
REQ-015 done  output  1  high for exactly one cycle while the FSM is in DONE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 Mode codes SHALL be:
- 000 hold
- 001 load D
- 010 SHL (LSB <- sin_r)
- 011 SHR logical (MSB <- sin_l)
- 100 SHR arithmetic (MSB kept)
- 101 ROL
- 110 ROR
- 111 clear to 0.
REQ-018 IDLE with start=1 and mode in {000, 001, 111}: at that edge Q SHALL take Q, D or 0 respectively, and the state SHALL become DONE.
REQ-019 IDLE with start=1 and a shift/rotate mode: at that edge the block SHALL latch mode and amt into internal registers and leave Q unchanged.
- If amt=0, the next state SHALL be DONE.
- Otherwise the next state SHALL be RUN with the step counter set to amt.
REQ-020 In RUN, each rising edge SHALL apply exactly one step of the latched mode and decrement the counter; the edge on which the counter reaches 0 SHALL also move the state to DONE.
REQ-021 Shift by A>0 issued at edge k: busy=1 in the cycles after edges k..k+A-1; final Q valid after edge k+A; done=1 in the cycle after edge k+A.
REQ-022 DONE SHALL last one cycle and then return to IDLE; a new command can be accepted on the edge that ends DONE only if the state is IDLE at that edge, so start in DONE SHALL be ignored.
REQ-023 start, mode, amt and D SHALL be ignored while in RUN or DONE; changes to them SHALL NOT affect an operation in progress.
REQ-024 sin_l and sin_r SHALL be sampled at every RUN step edge, so streamed serial data can change every cycle.
REQ-025 amt values greater than N SHALL be legal and SHALL perform amt single steps. An SHL/SHR beyond N steps yields serial-input bits only; a rotate by N restores the original Q.
REQ-026 Arithmetic right shift SHALL replicate Q[N-1] and ignore sin_l.
REQ-027 When start=0 in IDLE, Q SHALL hold.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for a clock edge, force Q=0, state=IDLE, counter=0, busy=0 and done=0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new start on the first edge.
REQ-030 All outputs SHALL remain stable at their reset values while reset_n=0, regardless of clk or start.

Verification (N=8, W=4)
REQ-031 Load: start, mode=001, D=8'hA5 -> Q=8'hA5 after the edge, done=1 for one cycle, busy never 1.
REQ-032 Arithmetic shift: Q=8'h96, start, mode=100, amt=3 -> busy=1 for 3 cycles, then Q=8'hF2, done=1 for one cycle.
REQ-033 Rotate: Q=8'h81, start, mode=101, amt=9 -> Q=8'h03 after 9 steps; mode=110, amt=8 on Q=8'h3C -> Q=8'h3C.
REQ-034 Serial stream: Q=0, mode=011, amt=8, sin_l driving 1,0,1,1,0,0,1,0 on successive steps -> Q=8'h4D, with sout_r tracking Q[0] each cycle.
REQ-035 Busy guard: start with mode=111 pulsed during RUN -> ignored, and the shift completes unchanged. Start with amt=0 and mode=010 -> done next cycle, Q unchanged.
REQ-036 Async reset: reset_n low mid-RUN between clock edges -> Q=0 and busy=0 immediately, no done pulse; a load issued after release succeeds.
